// File: rtl/rv_pkg.sv
// Shared widths and types for the operand-fetch slice sitting behind the register bank.
package rv_pkg;
    localparam int XLEN   = 64;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xword_t;
endpackage

// File: rtl/operand_fetch_if.sv
// Decode, register-bank, write-back and execute signals of the operand-fetch stage.
interface operand_fetch_if;
    import rv_pkg::*;

    logic      in_valid;
    logic      in_ready;
    reg_addr_t in_rs1;
    reg_addr_t in_rs2;
    reg_addr_t in_rd;
    logic      in_rd_we;
    reg_addr_t regreader1;
    reg_addr_t regreader2;
    xword_t    dataout1;
    xword_t    dataout2;
    logic      wb_write;
    reg_addr_t wb_addr;
    xword_t    wb_data;
    logic      flush;
    logic      out_valid;
    logic      out_ready;
    xword_t    op_a;
    xword_t    op_b;
    reg_addr_t rd_out;
    logic      rd_we_out;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
        output dataout1, dataout2, wb_write, wb_addr, wb_data, flush, out_ready,
        input  in_ready, regreader1, regreader2, out_valid, op_a, op_b, rd_out, rd_we_out
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
        input  dataout1, dataout2, wb_write, wb_addr, wb_data, flush, out_ready,
        output in_ready, regreader1, regreader2, out_valid, op_a, op_b, rd_out, rd_we_out
    );
endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Busy bitmap: one bit per architectural register with an in-flight producer.
module operand_scoreboard
    import rv_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      wb_write,
    input  reg_addr_t wb_addr,
    input  logic      kill_clr,
    input  reg_addr_t kill_addr,
    input  logic      set_en,
    input  reg_addr_t set_addr,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    input  logic      fwd1,
    input  logic      fwd2,
    input  logic      rd_we,
    input  reg_addr_t rd,
    output logic      hazard
);
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Later assignments win: a new producer overrides a same-cycle retire.
    always_comb begin
        busy_d = busy_q;
        if (wb_write)
            busy_d[wb_addr] = 1'b0;
        if (kill_clr)
            busy_d[kill_addr] = 1'b0;
        if (set_en && set_addr != '0)
            busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign hazard = (busy_q[rs1] && !fwd1)
                 || (busy_q[rs2] && !fwd2)
                 || (rd_we && rd != '0 && busy_q[rd] && !(wb_write && wb_addr == rd));
endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: bank read addressing, write-back bypass, hazard stall and ID/EX register.
module operand_fetch
    import rv_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    operand_fetch_if.slave bus
);
    logic      hit1, hit2, hazard, accept, ready;
    xword_t    fwd1, fwd2;
    logic      valid_q, we_q;
    xword_t    a_q, b_q;
    reg_addr_t rd_q;

    assign bus.regreader1 = bus.in_rs1;
    assign bus.regreader2 = bus.in_rs2;

    assign hit1 = bus.wb_write && bus.wb_addr == bus.in_rs1 && bus.in_rs1 != '0;
    assign hit2 = bus.wb_write && bus.wb_addr == bus.in_rs2 && bus.in_rs2 != '0;
    assign fwd1 = hit1 ? bus.wb_data : (bus.in_rs1 == '0 ? '0 : bus.dataout1);
    assign fwd2 = hit2 ? bus.wb_data : (bus.in_rs2 == '0 ? '0 : bus.dataout2);

    operand_scoreboard u_sb (
        .clock     (clock),
        .reset     (reset),
        .wb_write  (bus.wb_write),
        .wb_addr   (bus.wb_addr),
        .kill_clr  (bus.flush && valid_q && we_q),
        .kill_addr (rd_q),
        .set_en    (accept && bus.in_rd_we),
        .set_addr  (bus.in_rd),
        .rs1       (bus.in_rs1),
        .rs2       (bus.in_rs2),
        .fwd1      (hit1),
        .fwd2      (hit2),
        .rd_we     (bus.in_rd_we),
        .rd        (bus.in_rd),
        .hazard    (hazard)
    );

    assign ready  = !hazard && (!valid_q || bus.out_ready) && !bus.flush;
    assign accept = bus.in_valid && ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            a_q     <= fwd1;
            b_q     <= fwd2;
            rd_q    <= bus.in_rd;
            we_q    <= bus.in_rd_we;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.op_a      = a_q;
    assign bus.op_b      = b_q;
    assign bus.rd_out    = rd_q;
    assign bus.rd_we_out = we_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: bank model, abstract stage model, per-cycle compare.
module tb_operand_fetch;
    logic clock = 1'b0;
    logic reset;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [63:0] bank [32];
    assign bus.dataout1 = bank[bus.regreader1];
    assign bus.dataout2 = bank[bus.regreader2];

    logic        m_valid, m_we;
    logic [63:0] m_a, m_b;
    logic [4:0]  m_rd;
    bit   [31:0] m_busy;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic hit(input logic [4:0] s);
        return bus.wb_write && bus.wb_addr == s && s != 5'd0;
    endfunction

    function automatic logic [63:0] operand(input logic [4:0] s);
        if (hit(s)) return bus.wb_data;
        if (s == 5'd0) return 64'd0;
        return bank[s];
    endfunction

    function automatic logic exp_ready();
        logic stall;
        stall = (m_busy[bus.in_rs1] && !hit(bus.in_rs1))
             || (m_busy[bus.in_rs2] && !hit(bus.in_rs2))
             || (bus.in_rd_we && bus.in_rd != 5'd0 && m_busy[bus.in_rd]
                 && !(bus.wb_write && bus.wb_addr == bus.in_rd));
        return !stall && (!m_valid || bus.out_ready) && !bus.flush;
    endfunction

    always @(posedge clock or posedge reset) begin : model
        logic        acc;
        bit   [31:0] nb;
        if (reset) begin
            m_valid <= 1'b0;
            m_we    <= 1'b0;
            m_a     <= '0;
            m_b     <= '0;
            m_rd    <= '0;
            m_busy  <= '0;
            for (int i = 0; i < 32; i++)
                bank[i] <= 64'h1000 + 64'(i);
            bank[0] <= 64'hFFFF;
            bank[5] <= 64'd5;
            bank[7] <= 64'd7;
        end else begin
            acc = bus.in_valid && exp_ready();
            nb  = m_busy;
            if (bus.wb_write) nb[bus.wb_addr] = 1'b0;
            if (bus.flush && m_valid && m_we) nb[m_rd] = 1'b0;
            if (acc && bus.in_rd_we && bus.in_rd != 5'd0) nb[bus.in_rd] = 1'b1;
            m_busy <= nb;
            if (bus.flush) begin
                m_valid <= 1'b0;
            end else if (acc) begin
                m_valid <= 1'b1;
                m_a     <= operand(bus.in_rs1);
                m_b     <= operand(bus.in_rs2);
                m_rd    <= bus.in_rd;
                m_we    <= bus.in_rd_we;
            end else if (m_valid && bus.out_ready) begin
                m_valid <= 1'b0;
            end
            if (bus.wb_write && bus.wb_addr != 5'd0)
                bank[bus.wb_addr] <= bus.wb_data;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk1 ("cyc_in_ready",  bus.in_ready,  exp_ready());
            chk1 ("cyc_out_valid", bus.out_valid, m_valid);
            chk64("cyc_op_a",      bus.op_a,      m_a);
            chk64("cyc_op_b",      bus.op_b,      m_b);
            chk64("cyc_rd_out",    64'(bus.rd_out), 64'(m_rd));
            chk1 ("cyc_rd_we_out", bus.rd_we_out, m_we);
            chk64("cyc_regreader", {54'd0, bus.regreader2, bus.regreader1},
                  {54'd0, bus.in_rs2, bus.in_rs1});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] d, input logic we);
        bus.in_valid = v;
        bus.in_rs1   = r1;
        bus.in_rs2   = r2;
        bus.in_rd    = d;
        bus.in_rd_we = we;
    endtask

    task automatic wb(input logic w, input logic [4:0] a, input logic [63:0] d);
        bus.wb_write = w;
        bus.wb_addr  = a;
        bus.wb_data  = d;
    endtask

    initial begin
        reset = 1'b1;
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb(1'b0, 5'd0, 64'd0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        chk1 ("rst_in_ready",  bus.in_ready,  1'b1);
        chk1 ("rst_out_valid", bus.out_valid, 1'b0);
        chk64("rst_op_a",      bus.op_a,      64'd0);
        chk64("rst_op_b",      bus.op_b,      64'd0);

        // basic read x5, x7 -> x9
        issue(1'b1, 5'd5, 5'd7, 5'd9, 1'b1);
        tick();
        issue(1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
        #1;
        chk1 ("basic_valid", bus.out_valid, 1'b1);
        chk64("basic_op_a",  bus.op_a, 64'd5);
        chk64("basic_op_b",  bus.op_b, 64'd7);
        chk64("basic_rd",    64'(bus.rd_out), 64'd9);
        chk1 ("raw_stall",   bus.in_ready, 1'b0);
        repeat (2) tick();
        chk1 ("raw_stall_held", bus.in_ready, 1'b0);
        wb(1'b1, 5'd9, 64'hDEAD);
        #1;
        chk1 ("raw_fwd_ready", bus.in_ready, 1'b1);
        tick();
        wb(1'b0, 5'd0, 64'd0);
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk64("raw_fwd_op_a", bus.op_a, 64'hDEAD);

        issue(1'b1, 5'd9, 5'd5, 5'd0, 1'b0);
        #1;
        chk1 ("busy9_cleared", bus.in_ready, 1'b1);
        tick();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk64("bank9_op_a", bus.op_a, 64'hDEAD);

        // x0 reads zero and is never forwarded
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        wb(1'b1, 5'd0, 64'h1234);
        tick();
        wb(1'b0, 5'd0, 64'd0);
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk64("x0_op_a", bus.op_a, 64'd0);
        chk64("x0_op_b", bus.op_b, 64'd0);

        // backpressure hold, then flush kills and releases busy[3]
        issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        bus.out_ready = 1'b0;
        issue(1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1 ("hold_valid", bus.out_valid, 1'b1);
            chk64("hold_op_a",  bus.op_a, 64'h1001);
            chk1 ("hold_ready", bus.in_ready, 1'b0);
            tick();
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        issue(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
        #1;
        chk1 ("flush_valid",   bus.out_valid, 1'b0);
        chk1 ("flush_busy3",   bus.in_ready, 1'b1);
        tick();

        // async reset in the middle of a stall
        issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        issue(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
        #1;
        chk1 ("pre_rst_stall", bus.in_ready, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk1 ("arst_valid", bus.out_valid, 1'b0);
        chk1 ("arst_busy",  bus.in_ready, 1'b1);
        chk64("arst_op_a",  bus.op_a, 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // back-to-back accepts
        for (int i = 1; i <= 4; i++) begin
            issue(1'b1, 5'(i), 5'(i + 1), 5'(10 + i), 1'b1);
            #1;
            chk1 ("b2b_ready", bus.in_ready, 1'b1);
            tick();
        end

        // same-cycle retire and re-issue of x12: the new producer keeps it busy
        issue(1'b1, 5'd1, 5'd1, 5'd12, 1'b1);
        wb(1'b1, 5'd12, 64'hBEEF);
        #1;
        chk1 ("waw_wb_ready", bus.in_ready, 1'b1);
        tick();
        wb(1'b0, 5'd0, 64'd0);
        issue(1'b1, 5'd12, 5'd0, 5'd0, 1'b0);
        #1;
        chk1 ("set_wins", bus.in_ready, 1'b0);
        wb(1'b1, 5'd12, 64'hCAFE);
        tick();
        wb(1'b0, 5'd0, 64'd0);
        issue(1'b1, 5'd0, 5'd0, 5'd11, 1'b1);
        #1;
        chk64("fwd12_op_a", bus.op_a, 64'hCAFE);
        chk1 ("waw_stall",  bus.in_ready, 1'b0);
        tick();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch stage sitting directly downstream of the 64-bit, 32-entry register bank (bancoReg).
- Drives the bank's two read addresses and captures its two read data words into an ID/EX-style output register.
- Forwards same-cycle write-back data past the bank and stalls on RAW/WAW hazards using a 32-bit busy scoreboard.
- Handshakes valid/ready upstream (decode) and downstream (execute).

Parameters:
- XLEN, 64, data width; matches bancoReg datain/dataout.
- NREG, 32, number of architectural registers; address width is log2(NREG) = 5.

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_rs1  in  5  source register 1 address.
- in_rs2  in  5  source register 2 address.
- in_rd  in  5  destination register address.
- in_rd_we  in  1  instruction writes in_rd.
- regreader1  out  5  to bancoReg; equals in_rs1 combinationally.
- regreader2  out  5  to bancoReg; equals in_rs2 combinationally.
- dataout1  in  XLEN  from bancoReg; combinational read of regreader1.
- dataout2  in  XLEN  from bancoReg; combinational read of regreader2.
- wb_write  in  1  write-back strobe; same signal as the bank's write input.
- wb_addr  in  5  write-back address; same as regwriteaddress.
- wb_data  in  XLEN  write-back data; same as the bank's datain.
- flush  in  1  kill the instruction held in the output register.
- out_valid  out  1  op_a, op_b and rd_out are valid.
- out_ready  in  1  execute consumes the outputs this cycle.
- op_a  out  XLEN  operand 1 (registered).
- op_b  out  XLEN  operand 2 (registered).
- rd_out  out  5  destination address (registered).
- rd_we_out  out  1  destination write enable (registered).

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - out_valid=0, op_a=0, op_b=0, rd_out=0, rd_we_out=0.
  - busy[31:0]=0.
  - No write-back is lost on the clock edge after reset deasserts.
- Register x0:
  - Reads as 0 regardless of dataout.
  - Never marked busy; never forwarded.
  - in_rd_we with in_rd=0 sets nothing.
- Forwarding, per source s (combinational):
  - If wb_write && wb_addr==s && s!=0, the value is wb_data.
  - Else if s==0, the value is 0.
  - Else the value is the corresponding dataout.
- Hazard (combinational):
  - Condition: (busy[rs1] && !(fwd hit rs1)) || (busy[rs2] && !(fwd hit rs2)) || (in_rd_we && in_rd!=0 && busy[in_rd] && !(wb_write && wb_addr==in_rd)).
  - The WAW check guarantees at most one in-flight producer per register.
- Ready and accept:
  - in_ready = !hazard && (!out_valid || out_ready) && !flush.
  - accept = in_valid && in_ready.
- Output register: latency 1 cycle from accept to out_valid.
  - On accept: load forwarded operands, in_rd, in_rd_we; out_valid<=1.
  - Else if out_valid && out_ready: out_valid<=0.
  - Otherwise hold all outputs stable.
  - flush has priority: out_valid<=0 and no accept that cycle.
- Scoreboard, per bit i, at posedge:
  - Clear if wb_write && wb_addr==i.
  - Clear if flush && out_valid && rd_we_out && rd_out==i.
  - Set if accept && in_rd_we && in_rd==i && i!=0.
  - Set wins over clear when both occur on the same bit in the same cycle.
- Full throughput: back-to-back accepts are allowed while out_ready=1 and there is no hazard.

Decomposition:
- Shared package rv_pkg:
  - XLEN, NREG, REG_AW=5.
  - Typedefs reg_addr_t = logic [4:0] and xword_t = logic [XLEN-1:0].
- One sub-module, operand_scoreboard, holds the busy bitmap, the set/clear/priority logic and the hazard output.
- Forwarding muxes and the output register live in operand_fetch.

Test Plan:
- Reset release with no stimulus -> in_ready=1, out_valid=0, op_a=op_b=0, busy=0.
- Bank preloaded x5=5, x7=7; issue rs1=5, rs2=7, rd=9, rd_we=1 -> next cycle op_a=5, op_b=7, rd_out=9, out_valid=1, busy[9]=1.
- With busy[9]=1, issue rs1=9 and no write-back -> in_ready=0 held. Then pulse wb_write, wb_addr=9, wb_data=0xDEAD -> accepted that cycle with op_a=0xDEAD and busy[9]=0.
- Issue rs1=0, rs2=0 while the bank returns 0xFFFF for both -> op_a=op_b=0. wb_write with wb_addr=0 -> no forward.
- out_ready=0 with out_valid=1 -> outputs held for 3 cycles and in_ready=0. Then flush -> out_valid=0 and busy[rd_out] cleared.
- Assert reset asynchronously mid-stall with busy[3]=1 -> immediately out_valid=0 and busy=0.
